// File: rtl/intpol2_pkg.sv
// Shared definitions for the interpolator: FIFO sizing helpers, default sample
// width and the status register bit positions used by the core.
package intpol2_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

    // Status register bit indices
    localparam int unsigned STAT_DONE       = 0;
    localparam int unsigned STAT_BUSY       = 1;
    localparam int unsigned STAT_STOP_EMPTY = 2;
    localparam int unsigned STAT_STOP_AFULL = 3;
    localparam int unsigned STAT_BYPASS     = 5;

    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'(1) << addr_width;
    endfunction

    function automatic int unsigned afull_level(input int unsigned depth,
                                                input int unsigned margin);
        return depth - margin;
    endfunction

endpackage

// File: rtl/intpol2_iq_fifo_mem.sv
// Simple dual-port storage for the I/Q FIFO: synchronous write, registered read.
module intpol2_iq_fifo_mem #(
    parameter int unsigned WORD_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [WORD_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [WORD_WIDTH-1:0] rd_data_o
);

    localparam int unsigned DEPTH = 32'(1) << ADDR_WIDTH;

    logic [WORD_WIDTH-1:0] mem_q [DEPTH];
    logic [WORD_WIDTH-1:0] rd_data_q;

    // Array is not reset; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Output register holds its value between reads
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/intpol2_iq_fifo.sv
// Dual-lane I/Q synchronous FIFO with count-based flags and sticky
// overflow/underflow status for the interpolator core.
module intpol2_iq_fifo
    import intpol2_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH   = 6,
    parameter int unsigned AFULL_MARGIN = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data_I,
    input  logic [DATA_WIDTH-1:0] wr_data_Q,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data_I,
    output logic [DATA_WIDTH-1:0] rd_data_Q,
    output logic                  empty,
    output logic                  full,
    output logic                  afull,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH     = fifo_depth(ADDR_WIDTH);
    localparam int unsigned CW        = ADDR_WIDTH + 1;
    localparam int unsigned AFULL_LVL = afull_level(DEPTH, AFULL_MARGIN);
    localparam int unsigned MW        = 2 * DATA_WIDTH;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  afull_q, afull_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  push_ok_c, pop_ok_c;
    logic [MW-1:0]         rd_word;

    // Acceptance and next state; flags follow next-state count so they stay coherent
    always_comb begin
        push_ok_c = wr_en && !full_q && !clear;
        pop_ok_c  = rd_en && !empty_q && !clear;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q | (wr_en && full_q);
        udf_d     = udf_q | (rd_en && empty_q);

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (push_ok_c) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            if (pop_ok_c)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            if (push_ok_c && !pop_ok_c)      count_d = count_q + CW'(1);
            else if (pop_ok_c && !push_ok_c) count_d = count_q - CW'(1);
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
        afull_d = (count_d >= CW'(AFULL_LVL));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    intpol2_iq_fifo_mem #(
        .WORD_WIDTH (MW),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk       (clk),
        .rstn      (rstn),
        .wr_en_i   (push_ok_c),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i ({wr_data_I, wr_data_Q}),
        .rd_en_i   (pop_ok_c),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_word)
    );

    assign rd_data_I = rd_word[MW-1:DATA_WIDTH];
    assign rd_data_Q = rd_word[DATA_WIDTH-1:0];
    assign empty     = empty_q;
    assign full      = full_q;
    assign afull     = afull_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_intpol2_iq_fifo.sv
// Directed bench for intpol2_iq_fifo (DATA_WIDTH=32, DEPTH=64, AFULL_MARGIN=4).
module tb_intpol2_iq_fifo;

    logic        clk = 1'b0;
    logic        rstn;
    logic        clear;
    logic        wr_en;
    logic [31:0] wr_data_I, wr_data_Q;
    logic        rd_en;
    logic [31:0] rd_data_I, rd_data_Q;
    logic        empty, full, afull;
    logic [6:0]  count;
    logic        overflow, underflow;

    int vectors = 0;
    int errors  = 0;

    logic [63:0] q_m [$];
    logic [31:0] last_i = '0;
    logic [31:0] last_q = '0;

    intpol2_iq_fifo #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (6),
        .AFULL_MARGIN (4)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (clear),
        .wr_en     (wr_en),
        .wr_data_I (wr_data_I),
        .wr_data_Q (wr_data_Q),
        .rd_en     (rd_en),
        .rd_data_I (rd_data_I),
        .rd_data_Q (rd_data_Q),
        .empty     (empty),
        .full      (full),
        .afull     (afull),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic step(input logic we, input logic [31:0] di, input logic [31:0] dq,
                        input logic re, input logic clr);
        wr_en = we; wr_data_I = di; wr_data_Q = dq; rd_en = re; clear = clr;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
    endtask

    task automatic push(input logic [31:0] di, input logic [31:0] dq);
        step(1'b1, di, dq, 1'b0, 1'b0);
        q_m.push_back({di, dq});
    endtask

    task automatic check_reset_values(input string tag);
        vectors++;
        if (empty !== 1'b1 || full !== 1'b0 || afull !== 1'b0 || count !== 7'd0 ||
            overflow !== 1'b0 || underflow !== 1'b0 || rd_data_I !== 32'd0 || rd_data_Q !== 32'd0) begin
            errors++;
            $display("FAIL %s: e=%b f=%b af=%b cnt=%0d ovf=%b udf=%b rd=%h/%h, required 1 0 0 0 0 0 0/0",
                     tag, empty, full, afull, count, overflow, underflow, rd_data_I, rd_data_Q);
        end
    endtask

    task automatic test_reset;
        check_reset_values("reset_state");
    endtask

    task automatic test_basic;
        logic [31:0] exp_q [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
        push(32'd1, 32'hFFFF_FFFF);
        push(32'd2, 32'hFFFF_FFFE);
        push(32'd3, 32'hFFFF_FFFD);
        vectors++;
        if (count !== 7'd3 || empty !== 1'b0) begin
            errors++; $display("FAIL basic_count3: cnt=%0d empty=%b, required 3 0", count, empty);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, '0, '0, 1'b1, 1'b0);
            void'(q_m.pop_front());
            last_i = 32'(k + 1); last_q = exp_q[k];
            vectors++;
            if (rd_data_I !== last_i || rd_data_Q !== last_q || count !== 7'(2 - k)) begin
                errors++;
                $display("FAIL basic_pop%0d: rd=%h/%h cnt=%0d, required %h/%h cnt=%0d",
                         k, rd_data_I, rd_data_Q, count, last_i, last_q, 2 - k);
            end
        end
        vectors++;
        if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty: empty=%b, required 1", empty); end
    endtask

    task automatic test_fill_overflow;
        for (int k = 1; k <= 64; k++) begin
            push(32'(32'h100 + k), ~32'(32'h100 + k));
            vectors++;
            if (count !== 7'(k) || afull !== (k >= 60) || full !== (k == 64) || empty !== 1'b0) begin
                errors++;
                $display("FAIL fill_%0d: cnt=%0d af=%b f=%b e=%b, required cnt=%0d af=%b f=%b e=0",
                         k, count, afull, full, empty, k, (k >= 60), (k == 64));
            end
        end
        step(1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0);
        vectors++;
        if (overflow !== 1'b1 || count !== 7'd64 || full !== 1'b1 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow: ovf=%b cnt=%0d f=%b udf=%b, required 1 64 1 0", overflow, count, full, underflow);
        end
    endtask

    task automatic test_full_simul_wrap;
        logic [63:0] w;
        // push+pop from full: pop wins, push rejected
        step(1'b1, 32'h5555_5555, 32'h5555_5555, 1'b1, 1'b0);
        w = q_m.pop_front();
        vectors++;
        if (count !== 7'd63 || full !== 1'b0 || rd_data_I !== w[63:32] || rd_data_Q !== w[31:0]) begin
            errors++;
            $display("FAIL full_simul: cnt=%0d f=%b rd=%h/%h, required 63 0 %h/%h",
                     count, full, rd_data_I, rd_data_Q, w[63:32], w[31:0]);
        end
        for (int k = 0; k < 200; k++) begin
            logic [31:0] di, dq;
            di = 32'h2000_0000 + 32'(k); dq = 32'hA000_0000 ^ 32'(k);
            step(1'b1, di, dq, 1'b1, 1'b0);
            q_m.push_back({di, dq});
            w = q_m.pop_front();
            vectors++;
            if (count !== 7'd63 || rd_data_I !== w[63:32] || rd_data_Q !== w[31:0]) begin
                errors++;
                $display("FAIL stream_%0d: cnt=%0d rd=%h/%h, required 63 %h/%h",
                         k, count, rd_data_I, rd_data_Q, w[63:32], w[31:0]);
            end
        end
        for (int k = 0; k < 63; k++) begin
            step(1'b0, '0, '0, 1'b1, 1'b0);
            w = q_m.pop_front();
            vectors++;
            if (rd_data_I !== w[63:32] || rd_data_Q !== w[31:0] || count !== 7'(62 - k)) begin
                errors++;
                $display("FAIL drain_%0d: rd=%h/%h cnt=%0d, required %h/%h %0d",
                         k, rd_data_I, rd_data_Q, count, w[63:32], w[31:0], 62 - k);
            end
        end
        last_i = w[63:32]; last_q = w[31:0];
        vectors++;
        if (empty !== 1'b1 || overflow !== 1'b1) begin
            errors++; $display("FAIL drained_flags: e=%b ovf=%b, required 1 1", empty, overflow);
        end
    endtask

    task automatic test_underflow;
        step(1'b0, '0, '0, 1'b1, 1'b0);
        vectors++;
        if (underflow !== 1'b1 || count !== 7'd0 || rd_data_I !== last_i || rd_data_Q !== last_q) begin
            errors++;
            $display("FAIL underflow: udf=%b cnt=%0d rd=%h/%h, required 1 0 %h/%h",
                     underflow, count, rd_data_I, rd_data_Q, last_i, last_q);
        end
        step(1'b1, 32'd7, 32'd8, 1'b1, 1'b0);
        vectors++;
        if (count !== 7'd1 || empty !== 1'b0 || rd_data_I !== last_i || rd_data_Q !== last_q) begin
            errors++;
            $display("FAIL empty_simul: cnt=%0d e=%b rd=%h/%h, required 1 0 %h/%h",
                     count, empty, rd_data_I, rd_data_Q, last_i, last_q);
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        last_i = 32'd7; last_q = 32'd8;
        vectors++;
        if (rd_data_I !== 32'd7 || rd_data_Q !== 32'd8 || count !== 7'd0) begin
            errors++;
            $display("FAIL empty_simul_read: rd=%h/%h cnt=%0d, required 7/8 0", rd_data_I, rd_data_Q, count);
        end
    endtask

    task automatic test_clear;
        for (int k = 0; k < 10; k++) step(1'b1, 32'(k + 50), 32'(k + 60), 1'b0, 1'b0);
        vectors++;
        if (count !== 7'd10 || overflow !== 1'b1 || underflow !== 1'b1) begin
            errors++; $display("FAIL pre_clear: cnt=%0d ovf=%b udf=%b, required 10 1 1", count, overflow, underflow);
        end
        step(1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1);
        vectors++;
        if (count !== 7'd0 || empty !== 1'b1 || afull !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0 ||
            rd_data_I !== last_i || rd_data_Q !== last_q) begin
            errors++;
            $display("FAIL clear: cnt=%0d e=%b af=%b ovf=%b udf=%b rd=%h/%h, required 0 1 0 0 0 %h/%h",
                     count, empty, afull, overflow, underflow, rd_data_I, rd_data_Q, last_i, last_q);
        end
        step(1'b1, 32'h0000_0C1E, 32'h0000_0C1F, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        vectors++;
        if (rd_data_I !== 32'h0000_0C1E || rd_data_Q !== 32'h0000_0C1F || count !== 7'd0) begin
            errors++;
            $display("FAIL post_clear: rd=%h/%h cnt=%0d, required 00000c1e/00000c1f 0", rd_data_I, rd_data_Q, count);
        end
    endtask

    task automatic test_async_reset;
        for (int k = 0; k < 20; k++) step(1'b1, 32'(k + 900), 32'(k + 950), 1'b0, 1'b0);
        vectors++;
        if (count !== 7'd20) begin errors++; $display("FAIL pre_reset: cnt=%0d, required 20", count); end
        #2 rstn = 1'b0;
        #1;
        check_reset_values("async_reset");
        #3 rstn = 1'b1;
        step(1'b1, 32'h0000_00AA, 32'h0000_00BB, 1'b0, 1'b0);
        step(1'b1, 32'h0000_00CC, 32'h0000_00DD, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        vectors++;
        if (rd_data_I !== 32'h0000_00AA || rd_data_Q !== 32'h0000_00BB || count !== 7'd1) begin
            errors++;
            $display("FAIL post_reset_read: rd=%h/%h cnt=%0d, required 000000aa/000000bb 1",
                     rd_data_I, rd_data_Q, count);
        end
    endtask

    initial begin
        rstn = 1'b0; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wr_data_I = '0; wr_data_Q = '0;
        #12 rstn = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_fill_overflow();
        test_full_simul_wrap();
        test_underflow();
        test_clear();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
